// File: rtl/pcs_10g_pkg.sv
// Shared constants and types for the 10GBASE-R 64b/66b transmit path:
// block type fields, sync headers, 7-bit control codes, XGMII characters.
package pcs_10g_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] BT_CTRL = 8'h1e;
    localparam logic [7:0] BT_S0   = 8'h78;
    localparam logic [7:0] BT_S4   = 8'h33;
    localparam logic [7:0] BT_T0   = 8'h87;
    localparam logic [7:0] BT_T1   = 8'h99;
    localparam logic [7:0] BT_T2   = 8'haa;
    localparam logic [7:0] BT_T3   = 8'hb4;
    localparam logic [7:0] BT_T4   = 8'hcc;
    localparam logic [7:0] BT_T5   = 8'hd2;
    localparam logic [7:0] BT_T6   = 8'he1;
    localparam logic [7:0] BT_T7   = 8'hff;

    localparam logic [6:0] CC_IDLE = 7'h00;
    localparam logic [6:0] CC_ERR  = 7'h1e;

    localparam logic [7:0] XG_IDLE  = 8'h07;
    localparam logic [7:0] XG_START = 8'hfb;
    localparam logic [7:0] XG_TERM  = 8'hfd;
    localparam logic [7:0] XG_ERR   = 8'hfe;

    localparam logic [63:0] EBLOCK = {{8{CC_ERR}}, BT_CTRL};

    typedef enum logic [2:0] {ST_INIT, ST_C, ST_D, ST_T, ST_E} enc_state_t;
    typedef enum logic [2:0] {TY_C, TY_S, TY_D, TY_T, TY_E} blk_type_t;

    function automatic logic [7:0] term_type(input logic [2:0] k);
        case (k)
            3'd0:    return BT_T0;
            3'd1:    return BT_T1;
            3'd2:    return BT_T2;
            3'd3:    return BT_T3;
            3'd4:    return BT_T4;
            3'd5:    return BT_T5;
            3'd6:    return BT_T6;
            default: return BT_T7;
        endcase
    endfunction

endpackage

// File: rtl/pcs_10g_enc_fmt.sv
// Combinational classifier and block formatter for one XGMII word: returns the
// block type of the word and its 66-bit encoding as that type.
module pcs_10g_enc_fmt
    import pcs_10g_pkg::*;
(
    input  logic [63:0] data,
    input  logic [7:0]  ctrl,
    input  logic        ctrl_v,
    input  logic        idle_v,
    input  logic        start_v,
    input  logic        term_v,
    input  logic        err_v,
    input  logic [7:0]  keep,
    output blk_type_t   typ,
    output logic [1:0]  head,
    output logic [63:0] block
);

    logic [7:0]  lane [8];
    logic [3:0]  k;
    logic        keep_run;
    logic        tail_idle;
    logic        all_ic;
    logic        term_at;
    logic        is_s0;
    logic        is_s4;
    logic [55:0] ccodes;
    logic [55:0] tdata;

    always_comb begin
        k         = 4'd0;
        tail_idle = 1'b1;
        all_ic    = 1'b1;
        ccodes    = '0;
        tdata     = '0;
        for (int i = 0; i < 8; i++) begin
            lane[i] = data[8*i +: 8];
            k       = k + {3'b000, keep[i]};
        end
        for (int i = 0; i < 8; i++) begin
            if (4'(i) > k && lane[i] != XG_IDLE)
                tail_idle = 1'b0;
            if (lane[i] == XG_IDLE)
                ccodes[7*i +: 7] = CC_IDLE;
            else if (lane[i] == XG_ERR)
                ccodes[7*i +: 7] = CC_ERR;
            else
                all_ic = 1'b0;
        end
        for (int i = 0; i < 7; i++) begin
            if (keep[i])
                tdata[8*i +: 8] = lane[i];
        end
        // keep must be a contiguous LSB run that stops short of lane 7, so /T/ lives at lane k
        keep_run = ((keep & (keep + 8'd1)) == 8'h00) && (keep != 8'hff) && (ctrl == ~keep);
        term_at  = (lane[k[2:0]] == XG_TERM);
        is_s0    = (ctrl == 8'h01) && (lane[0] == XG_START);
        is_s4    = (ctrl == 8'h1f) && (lane[4] == XG_START) && (lane[0] == XG_IDLE) &&
                   (lane[1] == XG_IDLE) && (lane[2] == XG_IDLE) && (lane[3] == XG_IDLE);
    end

    always_comb begin
        typ   = TY_E;
        head  = SYNC_CTRL;
        block = EBLOCK;
        if (ctrl == 8'h00) begin
            typ   = TY_D;
            head  = SYNC_DATA;
            block = data;
        end else if (ctrl_v && start_v && !term_v && (is_s0 || is_s4)) begin
            typ   = TY_S;
            block = is_s0 ? {data[63:8], BT_S0} : {data[63:40], 32'h0, BT_S4};
        end else if (ctrl_v && term_v && !start_v && keep_run && term_at && tail_idle) begin
            typ   = TY_T;
            block = {tdata, term_type(k[2:0])};
        end else if (ctrl_v && (idle_v || err_v) && !start_v && !term_v &&
                     ctrl == 8'hff && all_ic) begin
            typ   = TY_C;
            block = {ccodes, BT_CTRL};
        end
    end

endmodule

// File: rtl/pcs_10g_enc.sv
// 10GBASE-R 64b/66b transmit encoder: clause 49 transmit state machine and
// registered 66-bit block output. Optional error-block counter: PCS_10G_ENC_ERR_CNT_EN.
module pcs_10g_enc
    import pcs_10g_pkg::*;
#(
    parameter int XGMII_DATA_W = 64,
    parameter int XGMII_CTRL_W = 8,
    parameter int KEEP_W       = 8,
    parameter int BLOCK_W      = 64,
    parameter int HEAD_W       = 2
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    valid_i,
    input  logic [XGMII_DATA_W-1:0] data_i,
    input  logic [XGMII_CTRL_W-1:0] ctrl_i,
    input  logic                    ctrl_v_i,
    input  logic                    idle_v_i,
    input  logic                    start_v_i,
    input  logic                    term_v_i,
    input  logic                    err_v_i,
    input  logic [KEEP_W-1:0]       keep_i,
    output logic                    valid_o,
    output logic [HEAD_W-1:0]       head_o,
    output logic [BLOCK_W-1:0]      block_o
`ifdef PCS_10G_ENC_ERR_CNT_EN
    ,
    output logic [15:0]             err_cnt_o
`endif
);

    enc_state_t  state;
    enc_state_t  nxt;
    blk_type_t   typ;
    logic [1:0]  fmt_head;
    logic [63:0] fmt_block;

    pcs_10g_enc_fmt u_fmt (
        .data    (data_i),
        .ctrl    (ctrl_i),
        .ctrl_v  (ctrl_v_i),
        .idle_v  (idle_v_i),
        .start_v (start_v_i),
        .term_v  (term_v_i),
        .err_v   (err_v_i),
        .keep    (keep_i),
        .typ     (typ),
        .head    (fmt_head),
        .block   (fmt_block)
    );

    always_comb begin
        nxt = ST_E;
        case (state)
            ST_INIT, ST_C, ST_T: begin
                if (typ == TY_C)      nxt = ST_C;
                else if (typ == TY_S) nxt = ST_D;
            end
            ST_D: begin
                if (typ == TY_D)      nxt = ST_D;
                else if (typ == TY_T) nxt = ST_T;
            end
            ST_E: begin
                if (typ == TY_C)      nxt = ST_C;
                else if (typ == TY_D) nxt = ST_D;
                else if (typ == TY_T) nxt = ST_T;
            end
            default: nxt = ST_E;
        endcase
    end

    // Stall cycles hold state and the last block; only valid_o drops
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= ST_INIT;
            valid_o <= 1'b0;
            head_o  <= '0;
            block_o <= '0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                state   <= nxt;
                head_o  <= (nxt == ST_E) ? SYNC_CTRL : fmt_head;
                block_o <= (nxt == ST_E) ? EBLOCK : fmt_block;
            end
        end
    end

`ifdef PCS_10G_ENC_ERR_CNT_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            err_cnt_o <= 16'h0000;
        else if (valid_i && nxt == ST_E && err_cnt_o != 16'hffff)
            err_cnt_o <= err_cnt_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pcs_10g_enc.sv
// Directed testbench for pcs_10g_enc with a scoreboard of expected blocks.
// Define PCS_10G_ENC_ERR_CNT_EN to also exercise the error counter.
module tb_pcs_10g_enc;

    localparam logic [1:0]  HC   = 2'b10;
    localparam logic [1:0]  HD   = 2'b01;
    localparam logic [63:0] EBLK = {{8{7'h1e}}, 8'h1e};
    localparam logic [63:0] IDLW = 64'h0707070707070707;

    typedef struct {
        string       tag;
        logic [1:0]  head;
        logic [63:0] block;
    } exp_t;

    logic        clk;
    logic        nreset;
    logic        valid_i;
    logic [63:0] data_i;
    logic [7:0]  ctrl_i;
    logic        ctrl_v_i;
    logic        idle_v_i;
    logic        start_v_i;
    logic        term_v_i;
    logic        err_v_i;
    logic [7:0]  keep_i;
    logic        valid_o;
    logic [1:0]  head_o;
    logic [63:0] block_o;
`ifdef PCS_10G_ENC_ERR_CNT_EN
    logic [15:0] err_cnt_o;
`endif

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    pcs_10g_enc dut (
        .clk       (clk),
        .nreset    (nreset),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .ctrl_i    (ctrl_i),
        .ctrl_v_i  (ctrl_v_i),
        .idle_v_i  (idle_v_i),
        .start_v_i (start_v_i),
        .term_v_i  (term_v_i),
        .err_v_i   (err_v_i),
        .keep_i    (keep_i),
        .valid_o   (valid_o),
        .head_o    (head_o),
        .block_o   (block_o)
`ifdef PCS_10G_ENC_ERR_CNT_EN
        ,
        .err_cnt_o (err_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Upstream decode-stage flags derived from the raw word
    task automatic send(input logic [63:0] d, input logic [7:0] c, input string tag,
                        input logic [1:0] eh, input logic [63:0] eb);
        logic       found;
        logic [7:0] fc;
        found = 1'b0;
        fc    = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (c[i] && !found) begin
                fc    = d[8*i +: 8];
                found = 1'b1;
            end
        end
        data_i    = d;
        ctrl_i    = c;
        keep_i    = ~c;
        ctrl_v_i  = |c;
        idle_v_i  = found && fc == 8'h07;
        term_v_i  = found && fc == 8'hfd;
        err_v_i   = found && fc == 8'hfe;
        start_v_i = (c[0] && d[7:0] == 8'hfb) || (c[4] && d[39:32] == 8'hfb);
        valid_i   = 1'b1;
        sb.push_back('{tag, eh, eb});
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (nreset && valid_o === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL sb_extra: got block %h expected no output", block_o);
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                assert ({head_o, block_o} === {e.head, e.block}) else begin
                    failures++;
                    $error("FAIL %s: got %b/%h expected %b/%h", e.tag, head_o, block_o,
                           e.head, e.block);
                end
            end
        end
    end

    initial begin
        nreset    = 1'b0;
        valid_i   = 1'b0;
        data_i    = '0;
        ctrl_i    = '0;
        ctrl_v_i  = 1'b0;
        idle_v_i  = 1'b0;
        start_v_i = 1'b0;
        term_v_i  = 1'b0;
        err_v_i   = 1'b0;
        keep_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_head", 64'(head_o), 64'd0);
        chk("rst_block", block_o, 64'd0);
`ifdef PCS_10G_ENC_ERR_CNT_EN
        chk("rst_errcnt", 64'(err_cnt_o), 64'd0);
`endif
        nreset = 1'b1;
        @(posedge clk);
        #1;

        repeat (3) send(IDLW, 8'hff, "idle", HC, 64'h1e);

        send(64'h66554433221100fb, 8'h01, "s0", HC, 64'h6655443322110078);
        send(64'h0123456789abcdef, 8'h00, "d1", HD, 64'h0123456789abcdef);
        send(64'hfedcba9876543210, 8'h00, "d2", HD, 64'hfedcba9876543210);
        send(64'h07070707fd332211, 8'hf8, "t3", HC, 64'h00000000332211b4);
        send(IDLW, 8'hff, "idle_after_t", HC, 64'h1e);

        send(64'haabbccfb07070707, 8'h1f, "s4", HC, 64'haabbcc0000000033);
        send(64'h07070707070707fd, 8'hff, "t0", HC, 64'h87);
        send(IDLW, 8'hff, "idle2", HC, 64'h1e);

        send(64'h1111111111111111, 8'h00, "d_after_c", HC, EBLK);
        send(64'hfd66554433221100, 8'h80, "t7_from_e", HC, 64'h66554433221100ff);
        send(IDLW, 8'hff, "idle_after_t7", HC, 64'h1e);

        send(64'h00000000000000fb, 8'h01, "s0_b", HC, 64'h78);
        send(64'h2222222222222222, 8'h00, "d_b", HD, 64'h2222222222222222);
        send(64'h00000000000000fb, 8'h01, "s_in_d", HC, EBLK);
        send(IDLW, 8'hff, "idle_after_e", HC, 64'h1e);

        send(64'h00000000000000fb, 8'h01, "s0_c", HC, 64'h78);
        send(64'h3333333333333333, 8'h00, "d_c", HD, 64'h3333333333333333);
        @(negedge clk);
        #1;
        nreset = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid_o), 64'd0);
        chk("midrst_block", block_o, 64'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        send(64'h4444444444444444, 8'h00, "d_after_rst", HC, EBLK);
        send(IDLW, 8'hff, "idle_after_rst", HC, 64'h1e);

        send(64'h00000000000000fb, 8'h01, "s0_st", HC, 64'h78);
        send(64'h5555555555555555, 8'h00, "d_st1", HD, 64'h5555555555555555);
        @(posedge clk);
        @(negedge clk);
        chk("stall_valid", 64'(valid_o), 64'd0);
        chk("stall_head", 64'(head_o), 64'(HD));
        chk("stall_block", block_o, 64'h5555555555555555);
        send(64'h6666666666666666, 8'h00, "d_st2", HD, 64'h6666666666666666);
        send(64'h0707fd5544332211, 8'he0, "t5", HC, 64'h00005544332211d2);
        send(IDLW, 8'hff, "idle_end", HC, 64'h1e);

`ifdef PCS_10G_ENC_ERR_CNT_EN
        @(negedge clk);
        #1;
        nreset = 1'b0;
        #1;
        chk("cnt_rst", 64'(err_cnt_o), 64'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        repeat (5) send(64'h0, 8'hff, "e_word", HC, EBLK);
        chk("cnt_5", 64'(err_cnt_o), 64'd5);
        for (int i = 0; i < 65535; i++) send(64'h0, 8'hff, "e_sat", HC, EBLK);
        chk("cnt_sat", 64'(err_cnt_o), 64'hffff);
        send(64'h0, 8'hff, "e_sat2", HC, EBLK);
        chk("cnt_hold", 64'(err_cnt_o), 64'hffff);
`endif

        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
